// File: rtl/mips_run_ctrl.sv
// Run controller for the mips core: sequences core reset, counts run cycles, detects a PC
// self-loop halt and enforces a watchdog. Define MIPS_RUN_CTRL_RETIRE_EN for retire_cnt/ipc_valid.
module mips_run_ctrl #(
   parameter int RST_CYCLES  = 4,
   parameter int TIMEOUT     = 100000,
   parameter int CNT_W       = 32,
   parameter int PC_W        = 32,
   parameter int HALT_REPEAT = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             pc_valid,
   input  logic [PC_W-1:0]  pc_i,
   output logic             core_reset,
   output logic             running,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic             done,
   output logic             timeout,
   output logic [PC_W-1:0]  halt_pc
`ifdef MIPS_RUN_CTRL_RETIRE_EN
   ,
   output logic [CNT_W-1:0] retire_cnt,
   output logic             ipc_valid
`endif
);

   localparam int         REP_W    = $clog2(HALT_REPEAT + 1);
   localparam logic [7:0] RST_LOAD = 8'(RST_CYCLES - 1);

   typedef enum logic [2:0] {S_IDLE, S_RST, S_RUN, S_DONE, S_TOUT} state_t;

   state_t           state, state_nxt;
   logic [7:0]       rst_cnt, rst_cnt_nxt;
   logic [REP_W-1:0] rep_cnt, rep_cnt_nxt;
   logic [PC_W-1:0]  last_pc, last_pc_nxt;
   logic [PC_W-1:0]  halt_pc_nxt;
   logic [CNT_W-1:0] cycle_cnt_nxt;
   logic             launch;

   // start is honoured only when no run is in progress
   assign launch = start && (state == S_IDLE || state == S_DONE || state == S_TOUT);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      // NOTE: every variable gets its hold value first so no path through the case infers a latch.
      state_nxt     = state;
      rst_cnt_nxt   = rst_cnt;
      rep_cnt_nxt   = rep_cnt;
      last_pc_nxt   = last_pc;
      halt_pc_nxt   = halt_pc;
      cycle_cnt_nxt = cycle_cnt;

      unique case (state)
         S_IDLE, S_DONE, S_TOUT: begin
            if (launch) begin
               state_nxt     = S_RST;
               rst_cnt_nxt   = RST_LOAD;
               rep_cnt_nxt   = '0;
               last_pc_nxt   = '0;
               halt_pc_nxt   = '0;
               cycle_cnt_nxt = '0;
            end
         end
         S_RST: begin
            if (rst_cnt == 8'd0) begin
               state_nxt     = S_RUN;
               cycle_cnt_nxt = CNT_W'(1);
            end else begin
               rst_cnt_nxt = rst_cnt - 8'd1;
            end
         end
         S_RUN: begin
            if (pc_valid) begin
               if (pc_i == last_pc) begin
                  rep_cnt_nxt = rep_cnt + REP_W'(1);
               end else begin
                  rep_cnt_nxt = REP_W'(1);
                  last_pc_nxt = pc_i;
               end
            end
            // halt takes priority over a watchdog expiry in the same cycle
            if (pc_valid && rep_cnt_nxt == REP_W'(HALT_REPEAT)) begin
               state_nxt   = S_DONE;
               halt_pc_nxt = pc_i;
            end else if (cycle_cnt >= CNT_W'(TIMEOUT)) begin
               state_nxt = S_TOUT;
            end else if (cycle_cnt != '1) begin
               cycle_cnt_nxt = cycle_cnt + CNT_W'(1);
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rst_cnt   <= '0;
         rep_cnt   <= '0;
         last_pc   <= '0;
         halt_pc   <= '0;
         cycle_cnt <= '0;
      end else begin
         rst_cnt   <= rst_cnt_nxt;
         rep_cnt   <= rep_cnt_nxt;
         last_pc   <= last_pc_nxt;
         halt_pc   <= halt_pc_nxt;
         cycle_cnt <= cycle_cnt_nxt;
      end
   end

   // NOTE: status outputs are flops loaded from state_nxt, so core_reset cannot glitch on state
   // decode and falls on exactly the edge that enters RUN.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         core_reset <= 1'b1;
         running    <= 1'b0;
         done       <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         core_reset <= (state_nxt == S_IDLE) || (state_nxt == S_RST);
         running    <= (state_nxt == S_RUN);
         done       <= (state_nxt == S_DONE);
         timeout    <= (state_nxt == S_TOUT);
      end
   end

`ifdef MIPS_RUN_CTRL_RETIRE_EN
   logic [CNT_W-1:0] retire_nxt;

   always_comb begin
      retire_nxt = retire_cnt;
      if (launch)
         retire_nxt = '0;
      else if (state == S_RUN && pc_valid && retire_cnt != '1)
         retire_nxt = retire_cnt + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) retire_cnt <= '0;
      else        retire_cnt <= retire_nxt;
   end

   assign ipc_valid = done && (retire_cnt != '0);
`endif

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Scoreboard bench for mips_run_ctrl: a per-run outcome model predicts each run's result and a
// monitor compares it when done/timeout appears; directed cases cover reset and restart.
module tb_mips_run_ctrl;

   localparam int RST_CYCLES  = 4;
   localparam int TIMEOUT     = 20;
   localparam int CNT_W       = 32;
   localparam int PC_W        = 32;
   localparam int HALT_REPEAT = 3;

   logic             clk      = 1'b0;
   logic             reset    = 1'b0;
   logic             start    = 1'b0;
   logic             pc_valid = 1'b0;
   logic [PC_W-1:0]  pc_i     = '0;
   logic             core_reset, running, done, timeout;
   logic [CNT_W-1:0] cycle_cnt;
   logic [PC_W-1:0]  halt_pc;
`ifdef MIPS_RUN_CTRL_RETIRE_EN
   logic [CNT_W-1:0] retire_cnt;
   logic             ipc_valid;
`endif

   typedef struct {
      bit              is_done;
      bit              is_tout;
      int              cnt;
      logic [PC_W-1:0] hpc;
      int              retired;
      int              lat;
   } result_t;

   result_t         exp_q[$];
   bit              stim_v  [1:TIMEOUT];
   logic [PC_W-1:0] stim_pc [1:TIMEOUT];
   int              checks = 0;
   int              errors = 0;

   mips_run_ctrl #(
      .RST_CYCLES (RST_CYCLES),
      .TIMEOUT    (TIMEOUT),
      .CNT_W      (CNT_W),
      .PC_W       (PC_W),
      .HALT_REPEAT(HALT_REPEAT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .pc_valid  (pc_valid),
      .pc_i      (pc_i),
      .core_reset(core_reset),
      .running   (running),
      .cycle_cnt (cycle_cnt),
      .done      (done),
      .timeout   (timeout),
      .halt_pc   (halt_pc)
`ifdef MIPS_RUN_CTRL_RETIRE_EN
      ,
      .retire_cnt(retire_cnt),
      .ipc_valid (ipc_valid)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h, expected %0h", name, act, exp);
      end
   endtask

   // Outcome of one run from the stimulus table: walk the run cycles, count identical valid PCs.
   function automatic result_t model();
      result_t         r;
      int              rep;
      int              ret;
      logic [PC_W-1:0] last;
      rep = 0; ret = 0; last = '0;
      r.is_done = 1'b0; r.is_tout = 1'b0; r.cnt = TIMEOUT; r.hpc = '0; r.retired = 0; r.lat = 0;
      for (int k = 1; k <= TIMEOUT; k++) begin
         if (stim_v[k]) begin
            ret++;
            if (stim_pc[k] == last) rep++;
            else begin
               rep  = 1;
               last = stim_pc[k];
            end
         end
         if (stim_v[k] && rep >= HALT_REPEAT) begin
            r.is_done = 1'b1;
            r.cnt     = k;
            r.hpc     = stim_pc[k];
            break;
         end
         if (k == TIMEOUT) begin
            r.is_tout = 1'b1;
            r.cnt     = k;
         end
      end
      r.retired = ret;
      r.lat     = RST_CYCLES + r.cnt + 1;
      return r;
   endfunction

   task automatic fill_incr();
      for (int k = 1; k <= TIMEOUT; k++) begin
         stim_v[k]  = 1'b1;
         stim_pc[k] = 32'h3000 + 32'(4 * k);
      end
   endtask

   task automatic fill_random();
      for (int k = 1; k <= TIMEOUT; k++) begin
         stim_v[k]  = ($urandom_range(0, 3) != 0);
         stim_pc[k] = 32'h3000 + 32'(4 * $urandom_range(0, 2));
      end
   endtask

   // Called just after a rising edge; leaves just after a rising edge.
   task automatic run_one(input bit poke_start);
      result_t r;
      r = model();
      exp_q.push_back(r);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("start_clears_done", done, 1'b0);
      check("start_clears_timeout", timeout, 1'b0);
      check("start_clears_halt_pc", halt_pc, '0);
      check("start_clears_cycle_cnt", cycle_cnt, '0);
      check("rst_core_reset", core_reset, 1'b1);
`ifdef MIPS_RUN_CTRL_RETIRE_EN
      check("start_clears_retire", retire_cnt, '0);
`endif
      for (int i = 0; i < RST_CYCLES; i++) begin
         pc_valid = 1'b1;
         pc_i     = 32'h3008;
         start    = poke_start && (i == 1);
         @(posedge clk); #1;
      end
      start = 1'b0;
      check("first_run_running", running, 1'b1);
      check("first_run_cycle_cnt", cycle_cnt, 1);
      for (int k = 1; k <= r.cnt; k++) begin
         pc_valid = stim_v[k];
         pc_i     = stim_pc[k];
         @(posedge clk); #1;
      end
      pc_valid = 1'b0;
      for (int i = 0; i < 4 && !(done || timeout); i++) begin
         @(posedge clk); #1;
      end
      check("result_within_bound", done || timeout, 1'b1);
      for (int i = 0; i < 3; i++) begin
         pc_valid = 1'($urandom_range(0, 1));
         pc_i     = 32'h3008;
         @(posedge clk); #1;
      end
      pc_valid = 1'b0;
      check("hold_cycle_cnt", cycle_cnt, r.cnt);
      check("hold_running", running, 1'b0);
      check("hold_done", done, r.is_done);
      check("hold_timeout", timeout, r.is_tout);
      check("hold_halt_pc", halt_pc, r.hpc);
   endtask

   initial begin : monitor
      int      edges;
      bit      armed;
      bit      fell;
      result_t e;
      edges = 0; armed = 1'b0; fell = 1'b0;
      forever begin
         @(posedge clk);
         if (armed) edges++;
         else if (start && reset) begin
            armed = 1'b1;
            edges = 1;
            fell  = 1'b0;
         end
         @(negedge clk);
         if (!reset) armed = 1'b0;
         else if (armed) begin
            if (!fell && !core_reset) begin
               fell = 1'b1;
               check("core_reset_fall_edges", edges, RST_CYCLES + 1);
            end
            if (done || timeout) begin
               armed = 1'b0;
               check("core_reset_fell_before_result", fell, 1'b1);
               check("scoreboard_depth", exp_q.size(), 1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  check("result_done", done, e.is_done);
                  check("result_timeout", timeout, e.is_tout);
                  check("result_cycle_cnt", cycle_cnt, e.cnt);
                  check("result_halt_pc", halt_pc, e.hpc);
                  check("result_latency_edges", edges, e.lat);
                  check("result_core_reset", core_reset, 1'b0);
`ifdef MIPS_RUN_CTRL_RETIRE_EN
                  check("result_retire_cnt", retire_cnt, e.retired);
                  check("result_ipc_valid", ipc_valid, e.is_done && (e.retired != 0));
`endif
               end
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin : stim
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("por_core_reset", core_reset, 1'b1);
      check("por_running", running, 1'b0);
      check("por_cycle_cnt", cycle_cnt, '0);
      check("por_done", done, 1'b0);
      check("por_timeout", timeout, 1'b0);
      check("por_halt_pc", halt_pc, '0);
      reset = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("idle_core_reset", core_reset, 1'b1);
      check("idle_running", running, 1'b0);
      check("idle_cycle_cnt", cycle_cnt, '0);
      check("idle_done", done, 1'b0);

      // Straight halt on 0x3008.
      fill_incr();
      stim_pc[1] = 32'h3000; stim_pc[2] = 32'h3004;
      stim_pc[3] = 32'h3008; stim_pc[4] = 32'h3008; stim_pc[5] = 32'h3008;
      run_one(1'b0);

      // Halt with bubbles between samples; restarts from DONE.
      fill_incr();
      stim_pc[1] = 32'h3008; stim_v[2] = 1'b0;
      stim_pc[3] = 32'h3008; stim_v[4] = 1'b0; stim_v[5] = 1'b0;
      stim_pc[6] = 32'h3008;
      run_one(1'b1);

      // 0x300C breaks the repeat run: no halt, watchdog fires.
      fill_incr();
      stim_pc[1] = 32'h3008; stim_pc[2] = 32'h3008; stim_pc[3] = 32'h300C;
      stim_pc[4] = 32'h3008; stim_pc[5] = 32'h3008;
      run_one(1'b0);

      // Always-incrementing PCs: timeout at TIMEOUT.
      fill_incr();
      run_one(1'b0);

      // Halt completing on the TIMEOUT cycle: done wins.
      fill_incr();
      stim_pc[TIMEOUT-2] = 32'h4000; stim_pc[TIMEOUT-1] = 32'h4000; stim_pc[TIMEOUT] = 32'h4000;
      run_one(1'b0);

      // Reset in the middle of a run.
      fill_incr();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (RST_CYCLES) @(posedge clk);
      #1;
      for (int k = 1; k < 7; k++) begin
         pc_valid = 1'b1;
         pc_i     = stim_pc[k];
         @(posedge clk); #1;
      end
      check("midrun_cycle_cnt", cycle_cnt, 7);
      check("midrun_running", running, 1'b1);
      #2 reset = 1'b0;
      #1;
      check("midrun_reset_core_reset", core_reset, 1'b1);
      check("midrun_reset_cycle_cnt", cycle_cnt, '0);
      check("midrun_reset_running", running, 1'b0);
      pc_valid = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("post_reset_idle_core_reset", core_reset, 1'b1);

      for (int n = 0; n < 30; n++) begin
         fill_random();
         run_one(n % 7 == 3);
      end

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
